draw_cmd_arbiter: RTL and testbench

DRAW_CMD_ARBITER -- requirements
Module: draw_cmd_arbiter

---
 rtl/draw_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 67 ++++++
 rtl/draw_cmd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_draw_cmd_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the draw command path: command width, opcodes,
// default buffer sizing and the enums used by the output arbiter.
package draw_pkg;

    localparam int CMD_WIDTH       = 32;
    localparam int DRAW_FIFO_DEPTH = 4;
    localparam int DRAW_STARVE_MAX = 4;

    localparam logic [3:0] OP_DRAW_CELL    = 4'h0;
    localparam logic [3:0] OP_CLEAR_SCREEN = 4'h1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    typedef enum logic {
        GNT_REQ0 = 1'b0,
        GNT_REQ1 = 1'b1
    } grant_e;

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock circular command buffer with a combinational head and registered count.
// A push is refused whenever the registered count shows full, even if a pop lands in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == {(AW + 1){1'b0}});
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/draw_cmd_arbiter.sv
// Merges game (requester 0) and overlay (requester 1) draw commands into one
// registered output stage, favouring requester 0 with a bounded starvation window.
module draw_cmd_arbiter #(
    parameter int CMD_WIDTH  = draw_pkg::CMD_WIDTH,
    parameter int FIFO_DEPTH = draw_pkg::DRAW_FIFO_DEPTH,
    parameter int STARVE_MAX = draw_pkg::DRAW_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic [CMD_WIDTH-1:0] in0_cmd,
    input  logic                 in0_vld,
    input  logic [CMD_WIDTH-1:0] in1_cmd,
    input  logic                 in1_vld,
    output logic [CMD_WIDTH-1:0] out_cmd,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 ovf0,
    output logic                 ovf1,
    output logic                 busy
);

    import draw_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);
    localparam logic [STV_W-1:0] STARVE_ONE = STV_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    function automatic logic [CNT_W-1:0] count_after(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        case ({inc, dec})
            2'b10:   count_after = cnt + CNT_ONE;
            2'b01:   count_after = cnt - CNT_ONE;
            default: count_after = cnt;
        endcase
    endfunction

    logic [CMD_WIDTH-1:0] f0_head, f1_head;
    logic                 f0_full, f0_empty, f1_full, f1_empty;
    logic [CNT_W-1:0]     f0_count, f1_count;
    logic                 push0, push1, pop0, pop1, load;
    grant_e               gnt;

    out_state_e           state_q, state_d;
    logic [CMD_WIDTH-1:0] out_cmd_q, out_cmd_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic                 busy_q, busy_d;

    cmd_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in0_cmd),
        .pop       (pop0),
        .head      (f0_head),
        .full      (f0_full),
        .empty     (f0_empty),
        .count     (f0_count)
    );

    cmd_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in1_cmd),
        .pop       (pop1),
        .head      (f1_head),
        .full      (f1_full),
        .empty     (f1_empty),
        .count     (f1_count)
    );

    // Grant selection, output FSM next-state, starvation counter and status flags.
    always_comb begin
        state_d   = state_q;
        out_cmd_d = out_cmd_q;
        starve_d  = starve_q;
        gnt       = GNT_REQ0;

        push0 = in0_vld & ~f0_full;
        push1 = in1_vld & ~f1_full;
        load  = enb & (~f0_empty | ~f1_empty) & ((state_q == OUT_EMPTY) | out_rdy);

        if (f0_empty) begin
            gnt = GNT_REQ1;
        end else if (~f1_empty && (starve_q == STARVE_LIM)) begin
            gnt = GNT_REQ1;
        end else begin
            gnt = GNT_REQ0;
        end

        pop0 = load & (gnt == GNT_REQ0);
        pop1 = load & (gnt == GNT_REQ1);

        case (state_q)
            OUT_EMPTY: begin
                if (load) begin
                    state_d   = OUT_HOLD;
                    out_cmd_d = (gnt == GNT_REQ1) ? f1_head : f0_head;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_HOLD: begin
                if (load) begin
                    state_d   = OUT_HOLD;
                    out_cmd_d = (gnt == GNT_REQ1) ? f1_head : f0_head;
                end else if (out_rdy) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_HOLD;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase

        // Requester 1 only counts as starved while it actually has something queued.
        if (f1_empty || pop1) begin
            starve_d = {STV_W{1'b0}};
        end else if (pop0 && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end

        ovf0_d = ovf0_q | (in0_vld & f0_full);
        ovf1_d = ovf1_q | (in1_vld & f1_full);
        busy_d = (count_after(f0_count, push0, pop0) != {CNT_W{1'b0}})
               | (count_after(f1_count, push1, pop1) != {CNT_W{1'b0}})
               | (state_d == OUT_HOLD);
    end

    // Output stage and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OUT_EMPTY;
            out_cmd_q <= {CMD_WIDTH{1'b0}};
            starve_q  <= {STV_W{1'b0}};
            ovf0_q    <= 1'b0;
            ovf1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_cmd_q <= out_cmd_d;
            starve_q  <= starve_d;
            ovf0_q    <= ovf0_d;
            ovf1_q    <= ovf1_d;
            busy_q    <= busy_d;
        end
    end

    assign out_cmd = out_cmd_q;
    assign out_vld = (state_q == OUT_HOLD);
    assign ovf0    = ovf0_q;
    assign ovf1    = ovf1_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Directed plus randomized bench for draw_cmd_arbiter, checked cycle by cycle
// against a queue-based reference model of the arbitration rules.
module tb_draw_cmd_arbiter;

    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst, enb, in0_vld, in1_vld, out_rdy;
    logic [CW-1:0] in0_cmd, in1_cmd, out_cmd;
    logic          out_vld, ovf0, ovf1, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [CW-1:0] q0[$];
    logic [CW-1:0] q1[$];
    logic          m_vld = 1'b0;
    logic [CW-1:0] m_cmd = '0;
    int            m_starve = 0;
    logic          m_ovf0 = 1'b0;
    logic          m_ovf1 = 1'b0;

    logic [CW-1:0] d[5];
    logic [CW-1:0] a[8];
    logic [CW-1:0] b;
    logic [CW-1:0] exp_seq[8];
    logic [CW-1:0] c[2];
    logic [CW-1:0] e[3];

    always #5 clk = ~clk;

    draw_cmd_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .in0_cmd (in0_cmd),
        .in0_vld (in0_vld),
        .in1_cmd (in1_cmd),
        .in1_vld (in1_vld),
        .out_cmd (out_cmd),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .ovf0    (ovf0),
        .ovf1    (ovf1),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge of the arbitration rules to the queues.
    task automatic model_edge();
        int n0, n1;
        bit ld, g1;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_vld = 1'b0;
            m_cmd = '0;
            m_starve = 0;
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
            return;
        end
        n0 = q0.size();
        n1 = q1.size();
        ld = enb && (n0 + n1 > 0) && (!m_vld || out_rdy);
        if (ld) begin
            g1 = (n0 == 0) || (n1 > 0 && m_starve == SMAX);
            if (g1) begin
                m_cmd = q1.pop_front();
                m_starve = 0;
            end else begin
                m_cmd = q0.pop_front();
                if (n1 > 0) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else m_starve = 0;
            end
            m_vld = 1'b1;
        end else begin
            if (m_vld && out_rdy) m_vld = 1'b0;
            if (n1 == 0) m_starve = 0;
        end
        if (in0_vld) begin
            if (n0 >= DEPTH) m_ovf0 = 1'b1;
            else q0.push_back(in0_cmd);
        end
        if (in1_vld) begin
            if (n1 >= DEPTH) m_ovf1 = 1'b1;
            else q1.push_back(in1_cmd);
        end
    endtask

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = (q0.size() > 0) || (q1.size() > 0) || m_vld;
        chk("model_out_vld", out_vld, m_vld);
        chk("model_out_cmd", out_cmd, m_cmd);
        chk("model_ovf0", ovf0, m_ovf0);
        chk("model_ovf1", ovf1, m_ovf1);
        chk("model_busy", busy, exp_busy);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; out_rdy = 1'b1;
        in0_vld = 1'b0; in1_vld = 1'b0; in0_cmd = '0; in1_cmd = '0;
        step();
        step();
        chk("reset_out_vld", out_vld, 1'b0);
        chk("reset_out_cmd", out_cmd, 32'h0000_0000);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;

        // Single command latency
        in0_cmd = 32'h1000_5DFF; in0_vld = 1'b1;
        step();
        in0_vld = 1'b0;
        chk("single_not_yet", out_vld, 1'b0);
        step();
        chk("single_vld", out_vld, 1'b1);
        chk("single_cmd", out_cmd, 32'h1000_5DFF);
        step();
        chk("single_done", out_vld, 1'b0);

        // Overflow on requester 1 with output stalled
        enb = 1'b0; out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d[k] = $urandom();
            in1_cmd = d[k]; in1_vld = 1'b1;
            step();
            if (k == 3) chk("ovf1_not_yet", ovf1, 1'b0);
        end
        in1_vld = 1'b0;
        chk("ovf1_set", ovf1, 1'b1);
        enb = 1'b1; out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ovf_drain_vld", out_vld, 1'b1);
            chk("ovf_drain_cmd", out_cmd, d[k]);
        end
        step();
        chk("ovf_drain_end", out_vld, 1'b0);
        chk("ovf1_sticky", ovf1, 1'b1);

        // Starvation bound
        enb = 1'b0; out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) a[k] = $urandom();
        b = $urandom();
        for (int k = 0; k < 4; k++) begin
            in0_cmd = a[k]; in0_vld = 1'b1;
            in1_cmd = b; in1_vld = (k == 0);
            step();
        end
        in0_vld = 1'b0; in1_vld = 1'b0;
        exp_seq[0] = a[0]; exp_seq[1] = a[1]; exp_seq[2] = a[2]; exp_seq[3] = a[3];
        exp_seq[4] = b;    exp_seq[5] = a[4]; exp_seq[6] = a[5]; exp_seq[7] = a[6];
        enb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in0_vld = (k >= 1 && k <= 3);
            in0_cmd = a[3 + k];
            step();
            chk("starve_vld", out_vld, 1'b1);
            chk("starve_order", out_cmd, exp_seq[k]);
        end
        in0_vld = 1'b0;
        step();
        chk("starve_end", out_vld, 1'b0);
        chk("starve_no_ovf0", ovf0, 1'b0);

        // Backpressure
        c[0] = $urandom(); c[1] = $urandom();
        enb = 1'b1; out_rdy = 1'b0;
        in0_cmd = c[0]; in0_vld = 1'b1;
        step();
        in0_cmd = c[1];
        step();
        in0_vld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_hold_vld", out_vld, 1'b1);
            chk("bp_hold_cmd", out_cmd, c[0]);
        end
        out_rdy = 1'b1;
        step();
        chk("bp_next_vld", out_vld, 1'b1);
        chk("bp_next_cmd", out_cmd, c[1]);
        step();
        chk("bp_end", out_vld, 1'b0);

        // Enable gating
        enb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e[k] = $urandom();
            in0_cmd = e[k]; in0_vld = 1'b1;
            step();
        end
        in0_vld = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("enb_gated", out_vld, 1'b0);
        end
        chk("enb_gated_busy", busy, 1'b1);
        enb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("enb_burst_vld", out_vld, 1'b1);
            chk("enb_burst_cmd", out_cmd, e[k]);
        end
        step();
        chk("enb_end", out_vld, 1'b0);

        // Reset mid-stream
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in1_cmd = $urandom(); in1_vld = 1'b1;
            step();
        end
        in1_vld = 1'b0;
        chk("pre_rst_hold", out_vld, 1'b1);
        chk("pre_rst_ovf1", ovf1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_vld", out_vld, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ovf0", ovf0, 1'b0);
        chk("rst_mid_ovf1", ovf1, 1'b0);
        out_rdy = 1'b1;
        step();
        chk("rst_mid_nothing", out_vld, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in0_vld = ($urandom_range(0, 99) < 45);
            in0_cmd = $urandom();
            in1_vld = ($urandom_range(0, 99) < 30);
            in1_cmd = $urandom();
            out_rdy = ($urandom_range(0, 99) < 70);
            enb     = ($urandom_range(0, 99) < 90);
            rst     = (i == 200);
            step();
        end
        rst = 1'b0; in0_vld = 1'b0; in1_vld = 1'b0; enb = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
